// File: rtl/trace_capture_buffer.sv
// Ring-buffer trace capture for retired instructions: PC-match trigger, post-trigger fill, oldest-first readout.
// Optional macro TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp and the RdTime output.
module trace_capture_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Valid,
  input  logic [XLEN-1:0]          PC,
  input  logic [31:0]              Instruction,
  input  logic                     RUWr,
  input  logic [4:0]               RdAddr,
  input  logic [XLEN-1:0]          RdData,
  input  logic                     Arm,
  input  logic                     TrigEn,
  input  logic [XLEN-1:0]          TrigPC,
  input  logic                     RdReq,
  output logic                     RdValid,
  output logic [XLEN-1:0]          RdPC,
  output logic [31:0]              RdInstr,
  output logic                     RdWbEn,
  output logic [4:0]               RdWbAddr,
  output logic [XLEN-1:0]          RdWbData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [1:0]               State
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          RdTime
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
  } entry_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_post;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_rd_valid;
  entry_t        r_rd_entry;
  entry_t        r_mem [DEPTH];
  entry_t        w_entry;
  logic          w_capture;
  logic          w_trigger;
  logic          w_read;
  logic [AW-1:0] w_rd_idx;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] w_ts_inc;

  // Stored stamp is the post-edge counter value, i.e. cycles elapsed since the Arm cycle.
  assign w_ts_inc = (&r_ts) ? r_ts : r_ts + 1'b1;

  always_ff @(posedge Clk) begin
    if (Rst || Arm) r_ts <= '0;
    else            r_ts <= w_ts_inc;
  end

  assign w_entry.ts = w_ts_inc;
  assign RdTime     = r_rd_entry.ts;
`endif

  assign w_entry.pc      = PC;
  assign w_entry.instr   = Instruction;
  assign w_entry.wb_en   = RUWr;
  assign w_entry.wb_addr = RdAddr;
  assign w_entry.wb_data = RdData;

  // When full, count[AW-1:0] is zero and the oldest entry sits at the write pointer.
  assign w_rd_idx = r_wp - r_count[AW-1:0];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_trigger    = 1'b0;
    w_read       = 1'b0;
    if (Arm) begin
      w_state_next = ARMED;
    end else begin
      case (r_state)
        ARMED: begin
          w_capture = Valid;
          w_trigger = Valid && TrigEn && (PC == TrigPC);
          if (w_trigger) w_state_next = (POST_TRIG == 0) ? DONE : POST;
        end
        POST: begin
          w_capture = Valid;
          if (Valid && r_post == AW'(1)) w_state_next = DONE;
        end
        DONE:    w_read = RdReq && (r_count != '0);
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_wp       <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_entry <= '0;
    end else if (Arm) begin
      r_state    <= ARMED;
      r_wp       <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= w_read;
      if (w_capture) begin
        r_wp <= r_wp + 1'b1;
        if (r_count == (AW+1)'(DEPTH)) r_overflow <= 1'b1;
        else                           r_count    <= r_count + 1'b1;
      end
      if (w_trigger)                         r_post <= AW'(POST_TRIG);
      else if (w_capture && r_state == POST) r_post <= r_post - 1'b1;
      if (w_read) begin
        r_count    <= r_count - 1'b1;
        r_rd_entry <= r_mem[w_rd_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; Count alone defines which entries are meaningful.
  always_ff @(posedge Clk) begin
    if (!Rst && w_capture) r_mem[r_wp] <= w_entry;
  end

  assign RdValid  = r_rd_valid;
  assign RdPC     = r_rd_entry.pc;
  assign RdInstr  = r_rd_entry.instr;
  assign RdWbEn   = r_rd_entry.wb_en;
  assign RdWbAddr = r_rd_entry.wb_addr;
  assign RdWbData = r_rd_entry.wb_data;
  assign Count    = r_count;
  assign Overflow = r_overflow;
  assign State    = r_state;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_trace_capture_buffer;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 2;
  localparam int TS_W      = 16;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic            Clk = 1'b0;
  logic            Rst, Valid, RUWr, Arm, TrigEn, RdReq;
  logic [XLEN-1:0] PC, RdData, TrigPC;
  logic [31:0]     Instruction;
  logic [4:0]      RdAddr;
  logic            RdValid, RdWbEn, Overflow;
  logic [XLEN-1:0] RdPC, RdWbData;
  logic [31:0]     RdInstr;
  logic [4:0]      RdWbAddr;
  logic [CW-1:0]   Count;
  logic [1:0]      State;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] RdTime;
`endif

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)) dut (
    .Clk(Clk), .Rst(Rst), .Valid(Valid), .PC(PC), .Instruction(Instruction), .RUWr(RUWr),
    .RdAddr(RdAddr), .RdData(RdData), .Arm(Arm), .TrigEn(TrigEn), .TrigPC(TrigPC), .RdReq(RdReq),
    .RdValid(RdValid), .RdPC(RdPC), .RdInstr(RdInstr), .RdWbEn(RdWbEn), .RdWbAddr(RdWbAddr),
    .RdWbData(RdWbData), .Count(Count), .Overflow(Overflow), .State(State)
`ifdef TRACE_TIMESTAMP_EN
    , .RdTime(RdTime)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb;
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned ts;
  } ent_t;

  // Reference model: entries as a queue, state as a plain phase number (0 idle .. 3 done).
  ent_t        m_q[$];
  ent_t        m_rd;
  int          m_state, m_post;
  bit          m_ovf, m_rv;
  int unsigned m_ts;

  int total = 0;
  int bad   = 0;
  bit          g_te;
  logic [31:0] g_tp;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_post = 0;
    m_ovf  = 1'b0;
    m_rv   = 1'b0;
    m_ts   = 0;
  endtask

  task automatic model_step();
    ent_t e;
    if (Rst) begin
      model_clear();
      m_state = 0;
      m_rd    = '{default: 0};
    end else if (Arm) begin
      model_clear();
      m_state = 1;
    end else begin
      m_rv = 1'b0;
      if (m_ts < (2**TS_W) - 1) m_ts++;
      if ((m_state == 1 || m_state == 2) && Valid) begin
        e = '{pc: PC, instr: Instruction, wb: RUWr, addr: RdAddr, data: RdData, ts: m_ts};
        m_q.push_back(e);
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        if (m_state == 1 && TrigEn && PC == TrigPC) begin
          if (POST_TRIG == 0) m_state = 3;
          else begin
            m_state = 2;
            m_post  = POST_TRIG;
          end
        end else if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end else if (m_state == 3 && RdReq && m_q.size() > 0) begin
        m_rd = m_q.pop_front();
        m_rv = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("state", State, m_state);
    check("count", Count, m_q.size());
    check("overflow", Overflow, m_ovf);
    check("rdvalid", RdValid, m_rv);
    check("rdpc", RdPC, m_rd.pc);
    check("rdinstr", RdInstr, m_rd.instr);
    check("rdwben", RdWbEn, m_rd.wb);
    check("rdwbaddr", RdWbAddr, m_rd.addr);
    check("rdwbdata", RdWbData, m_rd.data);
`ifdef TRACE_TIMESTAMP_EN
    check("rdtime", RdTime, TS_W'(m_rd.ts));
`endif
  endtask

  task automatic step(input bit rst, input bit arm, input bit valid, input bit te, input bit rdreq,
                      input logic [31:0] pc, input logic [31:0] tp);
    @(negedge Clk);
    Rst         = rst;
    Arm         = arm;
    Valid       = valid;
    TrigEn      = te;
    RdReq       = rdreq;
    PC          = pc;
    TrigPC      = tp;
    Instruction = $urandom;
    RUWr        = 1'($urandom);
    RdAddr      = 5'($urandom);
    RdData      = $urandom;
    model_step();
    @(posedge Clk);
    #1;
    compare();
  endtask

  task automatic retire(input logic [31:0] pc); step(1'b0, 1'b0, 1'b1, g_te, 1'b0, pc, g_tp); endtask
  task automatic nop();                         step(1'b0, 1'b0, 1'b0, g_te, 1'b0, 32'h0, g_tp); endtask
  task automatic rd();                          step(1'b0, 1'b0, 1'b0, g_te, 1'b1, 32'h0, g_tp); endtask
  task automatic arm();                         step(1'b0, 1'b1, 1'b0, g_te, 1'b0, 32'h0, g_tp); endtask

  initial begin
    Rst = 1'b1; Arm = 1'b0; Valid = 1'b0; TrigEn = 1'b0; RdReq = 1'b0;
    PC = '0; TrigPC = '0; Instruction = '0; RUWr = 1'b0; RdAddr = '0; RdData = '0;
    m_state = 0;
    m_rd    = '{default: 0};
    model_clear();

    // Reset dominates Valid, Arm and RdReq.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h8);

    // Basic trigger at 0x8 with two post-trigger entries, then six reads.
    g_te = 1'b1; g_tp = 32'h8;
    arm();
    for (int i = 0; i < 5; i++) retire(32'(i * 4));
    retire(32'h14);
    repeat (6) rd();

    // Wrap with overflow, then trigger near the end.
    g_te = 1'b0; g_tp = 32'h30;
    arm();
    for (int i = 0; i < 12; i++) retire(32'(i * 4));
    g_te = 1'b1;
    for (int i = 0; i < 3; i++) retire(32'h30 + 32'(i * 4));
    repeat (9) rd();

    // Gaps in the post-trigger window.
    g_tp = 32'h100;
    arm();
    retire(32'hF0);
    retire(32'h100);
    nop(); retire(32'h104); nop(); nop(); retire(32'h108);
    retire(32'h10C);
    repeat (5) rd();

    // Reset while in POST; afterwards a matching PC must not be captured.
    arm();
    retire(32'h100);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h104, g_tp);
    retire(32'h100);
    rd();

    // Arm while DONE with three entries and a simultaneous retire.
    arm();
    retire(32'h100); retire(32'h104); retire(32'h108);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, g_tp);
    nop();
    g_tp = 32'h300;
    retire(32'h200);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r_arm;
      r_arm = ($urandom_range(0, 39) == 0);
      if (r_arm) g_tp = 32'($urandom_range(0, 15)) << 2;
      step(($urandom_range(0, 199) == 0), r_arm, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 15)) << 2, g_tp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Parametrised, synthesizable capture buffer for retired instructions of the single-cycle RISC-V core.
- Records PC, instruction and register write-back into a ring buffer.
- Freezes on a PC-match trigger after a programmable number of post-trigger entries, then offers handshaked oldest-first readout.
- Instantiated beside the core and fed from its retire/write-back signals. It replaces per-cycle text dumps with on-chip capture.

Parameters:
XLEN, 32, data/address width of PC, Instruction, RdData
DEPTH, 16, entries in ring; power of two, >= 2
POST_TRIG, 4, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1
TS_W, 16, timestamp width; used only with TRACE_TIMESTAMP_EN

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous active-high reset
Valid  in  1  one instruction retires this cycle
PC  in  XLEN  PC of retiring instruction
Instruction  in  32  retiring instruction word
RUWr  in  1  register-file write enable of retiring instruction
RdAddr  in  5  destination register
RdData  in  XLEN  write-back data
Arm  in  1  pulse: clear buffer and start capture
TrigEn  in  1  enables PC-match trigger
TrigPC  in  XLEN  trigger PC
RdReq  in  1  request one entry (honoured only in DONE)
RdValid  out  1  read data valid, one cycle after accepted RdReq
RdPC  out  XLEN  read entry PC
RdInstr  out  32  read entry instruction
RdWbEn  out  1  read entry RUWr
RdWbAddr  out  5  read entry RdAddr
RdWbData  out  XLEN  read entry RdData
Count  out  $clog2(DEPTH)+1  valid entries held
Overflow  out  1  at least one entry overwritten since Arm
State  out  2  IDLE=0, ARMED=1, POST=2, DONE=3

Behaviour:
- Reset (Rst=1 at edge): State=IDLE; write pointer, Count, post counter, Overflow = 0; RdValid=0; all Rd* outputs = 0. Rst overrides every other input in every state, including mid-POST and mid-readout.
- Arm has priority over capture and readout in any state:
  - next State=ARMED;
  - Count, write pointer, Overflow, post counter cleared;
  - a Valid in the Arm cycle is discarded;
  - RdValid=0 next cycle.
- IDLE: no capture; RdReq ignored.
- ARMED, Valid=1:
  - entry written at write pointer;
  - pointer increments mod DEPTH;
  - Count saturates at DEPTH;
  - if Count==DEPTH before the write, the oldest entry is lost and Overflow <= 1.
- Trigger condition: ARMED, Valid=1, TrigEn=1, PC==TrigPC.
  - The trigger instruction itself is captured.
  - POST_TRIG>0: State <= POST, post counter <= POST_TRIG.
  - POST_TRIG==0: State <= DONE.
- POST, Valid=1:
  - capture as in ARMED;
  - post counter decrements;
  - the capture that brings it to 0 moves State <= DONE.
  - Valid=0 cycles do not decrement.
  - No further trigger detection.
- DONE: capture disabled; Valid ignored.
- Readout (DONE only):
  - RdReq with Count>0 is accepted.
  - Next cycle: RdValid=1 and Rd* show the oldest entry, at index (wp - Count) mod DEPTH sampled at the request.
  - Count decrements at the same edge.
  - Back-to-back RdReq yields one entry per cycle.
  - RdReq with Count==0, or outside DONE, gives RdValid=0.
  - Rd* hold their last value while RdValid=0.
  - Emptying the buffer leaves State=DONE; only Arm or Rst leave DONE.
- Count never exceeds DEPTH. Pointer arithmetic is modulo DEPTH and wraps without gaps.
- Storage is a register array with no read-during-write hazard, since capture and readout are mutually exclusive by state.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - a TS_W-bit cycle counter clears on Rst and on Arm;
  - it increments every cycle and saturates at all-ones;
  - its value is stored with each entry;
  - extra output port RdTime (out, TS_W) is presented alongside the other Rd* outputs, with the same timing and reset value 0.
- Undefined: no counter, no RdTime port, entry width unchanged.

Test Plan:
- Reset: Rst=1 for 2 cycles with Valid=1, Arm=1 -> State=0, Count=0, Overflow=0, RdValid=0, Rd*=0.
- Basic trigger (DEPTH=8, POST_TRIG=2, TrigPC=0x8, TrigEn=1):
  - stimulus: Arm, then retire PC 0x0,0x4,0x8,0xC,0x10 on consecutive cycles;
  - response: State=POST after 0x8, DONE after 0x10, Count=5;
  - five RdReq return 0x0,0x4,0x8,0xC,0x10 each one cycle later; a sixth RdReq gives RdValid=0.
- Wrap (DEPTH=8, POST_TRIG=2, TrigEn=0):
  - stimulus: Arm, retire PC 0x00..0x2C (12 instrs);
  - intermediate response: Count=8, Overflow=1, State=ARMED;
  - stimulus: set TrigEn=1, TrigPC=0x30, retire 0x30,0x34,0x38;
  - response: DONE, Count=8; readout 0x1C,0x20,0x24,0x28,0x2C,0x30,0x34,0x38.
- Gaps in POST: trigger, then Valid pattern 0,1,0,0,1 -> DONE only on the second Valid; Count equals entries captured.
- Mid-operation:
  - Rst asserted in POST -> IDLE, Count=0; later Valid with PC==TrigPC produces no capture.
  - Arm in DONE with Count=3 and Valid=1 -> ARMED, Count=0, Overflow=0, that instruction not captured.
- TRACE_TIMESTAMP_EN:
  - stimulus: Arm at cycle 0, retire at cycles 3, 4, 9 with POST_TRIG=0 and trigger at cycle 9;
  - response: RdTime reads 3, 4, 9.
